// File: rtl/mix_columns_enc_pkg.sv
// Shared constants and types for the AES forward MixColumns unit.
// The working state is one 128-bit register processed as four 32-bit columns.
package mix_columns_enc_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int         STATE_W  = 128;
    localparam int         COL_W    = 32;
    localparam int         NUM_COLS = STATE_W / COL_W;

    typedef logic [STATE_W-1:0] aes_state_t;
    typedef logic [COL_W-1:0]   aes_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/mix_columns_enc_if.sv
// Valid/ready state transfer bundle; the producer uses master, the consumer slave.
interface mix_columns_enc_if;
    import mix_columns_enc_pkg::*;

    logic       valid;
    logic       ready;
    aes_state_t state;

    modport master (
        output valid,
        output state,
        input  ready
    );

    modport slave (
        input  valid,
        input  state,
        output ready
    );

endinterface

// File: rtl/galois2.sv
// GF(2^8) multiply-by-two (xtime) with the AES reduction polynomial.
module galois2
    import mix_columns_enc_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);

endmodule

// File: rtl/mix_columns_enc_mix_coluna.sv
// One forward MixColumns column: circulant {02,03,01,01} over GF(2^8).
// Byte 0 of the column sits in the most significant bits.
module mix_coluna
    import mix_columns_enc_pkg::*;
(
    input  aes_col_t col,
    output aes_col_t mixed
);

    logic [3:0][7:0] a;
    logic [3:0][7:0] a2;
    logic [3:0][7:0] a3;

    assign a[0] = col[31:24];
    assign a[1] = col[23:16];
    assign a[2] = col[15:8];
    assign a[3] = col[7:0];

    for (genvar i = 0; i < 4; i++) begin : g_xtime
        galois2 u_galois2 (
            .a (a[i]),
            .y (a2[i])
        );
        assign a3[i] = a2[i] ^ a[i];
    end

    // Each output byte is a five-input XOR tree after the xtime stage.
    assign mixed[31:24] = a2[0] ^ a3[1] ^ a[2]  ^ a[3];
    assign mixed[23:16] = a[0]  ^ a2[1] ^ a3[2] ^ a[3];
    assign mixed[15:8]  = a[0]  ^ a[1]  ^ a2[2] ^ a3[3];
    assign mixed[7:0]   = a3[0] ^ a[1]  ^ a[2]  ^ a2[3];

endmodule

// File: rtl/mix_columns_enc.sv
// Sequential AES MixColumns: accepts a state, mixes one column per cycle
// (column 0 first), then presents the result until downstream takes it.
module mix_columns_enc
    import mix_columns_enc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    mix_columns_enc_if.slave         in_if,
    mix_columns_enc_if.master        out_if
);

    fsm_state_t state_q;
    fsm_state_t state_d;
    logic [1:0] col_q;
    logic [1:0] col_d;
    aes_state_t work_q;
    aes_state_t work_d;
    aes_col_t   col_cur;
    aes_col_t   col_mixed;

    // Handshake outputs depend on the FSM state alone.
    assign in_if.ready  = (state_q == IDLE);
    assign out_if.valid = (state_q == DONE);
    assign out_if.state = work_q;

    always_comb begin
        col_cur = work_q[127:96];
        case (col_q)
            2'd0: col_cur = work_q[127:96];
            2'd1: col_cur = work_q[95:64];
            2'd2: col_cur = work_q[63:32];
            2'd3: col_cur = work_q[31:0];
        endcase
    end

    mix_coluna u_mix_coluna (
        .col   (col_cur),
        .mixed (col_mixed)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (in_if.valid) begin
                    work_d  = in_if.state;
                    col_d   = 2'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                case (col_q)
                    2'd0: work_d[127:96] = col_mixed;
                    2'd1: work_d[95:64]  = col_mixed;
                    2'd2: work_d[63:32]  = col_mixed;
                    2'd3: work_d[31:0]   = col_mixed;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_if.ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset discards any partial result along with the FSM position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_enc.sv
// Directed bench for mix_columns_enc: FIPS-197 vectors, backpressure, reset, streaming, round trip.
module tb_mix_columns_enc;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    mix_columns_enc_if in_if ();
    mix_columns_enc_if out_if ();

    mix_columns_enc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_if  (in_if),
        .out_if (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] v;
        p = 8'h00;
        v = x;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ v;
            v = xt(v);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(a2, 4'hD) ^ gmul(a3, 4'h9);
            r[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'hE) ^ gmul(a2, 4'hB) ^ gmul(a3, 4'hD);
            r[111 - 32*c -: 8] = gmul(a0, 4'hD) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'hE) ^ gmul(a3, 4'hB);
            r[103 - 32*c -: 8] = gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'hE);
        end
        return r;
    endfunction

    task automatic run_state(input logic [127:0] s, output logic [127:0] r, output int lat);
        int n;
        n = 0;
        while (!in_if.ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_if.valid = 1'b1;
        in_if.state = s;
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        lat = 0;
        while (!out_if.valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = out_if.state;
        out_if.ready = 1'b1;
        @(posedge clk); #1;
        out_if.ready = 1'b0;
    endtask

    localparam logic [127:0] FULL_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FULL_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] ALT_IN   = 128'hf0f0f0f0_0000000f_12345678_9abcdef0;

    logic [31:0]  col_in  [6];
    logic [31:0]  col_exp [6];
    logic [127:0] bb_in   [3];
    logic [127:0] bb_exp  [3];
    int           acc_t   [3];
    logic [127:0] res;
    int           lat;
    int           ni;
    int           no;
    logic         acc;
    logic         hs;
    logic [127:0] rnd;

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.state  = '0;
        out_if.ready = 1'b0;

        col_in[0] = 32'hdb135345; col_exp[0] = 32'h8e4da1bc;
        col_in[1] = 32'hf20a225c; col_exp[1] = 32'h9fdc589d;
        col_in[2] = 32'hd4d4d4d5; col_exp[2] = 32'hd5d5d7d6;
        col_in[3] = 32'h2d26314c; col_exp[3] = 32'h4d7ebdf8;
        col_in[4] = 32'h01010101; col_exp[4] = 32'h01010101;
        col_in[5] = 32'hc6c6c6c6; col_exp[5] = 32'hc6c6c6c6;

        bb_in[0]  = FULL_IN;
        bb_exp[0] = FULL_OUT;
        bb_in[1]  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        bb_exp[1] = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
        bb_in[2]  = 128'h01010101_c6c6c6c6_2d26314c_db135345;
        bb_exp[2] = 128'h01010101_c6c6c6c6_4d7ebdf8_8e4da1bc;
        for (int i = 0; i < 3; i++) acc_t[i] = 0;

        // Reset state
        #1;
        check("rst_in_ready", 128'(in_if.ready), 128'd1);
        check("rst_out_valid", 128'(out_if.valid), 128'd0);
        check("rst_out_state", out_if.state, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-column vectors in column 0
        for (int i = 0; i < 6; i++) begin
            run_state({col_in[i], 96'h0}, res, lat);
            check($sformatf("col_vec%0d", i), res, {col_exp[i], 96'h0});
        end

        // Full state and latency
        run_state(FULL_IN, res, lat);
        check("full_state", res, FULL_OUT);
        check("full_latency", 128'(lat), 128'd4);

        // Backpressure with a spurious in_valid during CALC/DONE
        in_if.valid = 1'b1;
        in_if.state = FULL_IN;
        @(posedge clk); #1;
        in_if.state = ALT_IN;
        lat = 0;
        while (!out_if.valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_first", out_if.state, FULL_OUT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_state%0d", i), out_if.state, FULL_OUT);
            check($sformatf("bp_valid%0d", i), 128'(out_if.valid), 128'd1);
            check($sformatf("bp_in_ready%0d", i), 128'(in_if.ready), 128'd0);
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        @(posedge clk); #1;
        out_if.ready = 1'b0;
        check("bp_after_valid", 128'(out_if.valid), 128'd0);
        check("bp_after_in_ready", 128'(in_if.ready), 128'd1);

        // Asynchronous reset while column 2 is pending
        in_if.valid = 1'b1;
        in_if.state = FULL_IN;
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_if.valid), 128'd0);
        check("mid_rst_out_state", out_if.state, 128'h0);
        check("mid_rst_in_ready", 128'(in_if.ready), 128'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_state(bb_in[1], res, lat);
        check("post_rst_state", res, bb_exp[1]);

        // Back-to-back stream with downstream always ready
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        in_if.state  = bb_in[0];
        ni = 0;
        no = 0;
        for (int t = 0; t < 60 && no < 3; t++) begin
            acc = in_if.valid && in_if.ready;
            hs  = out_if.valid && out_if.ready;
            if (hs) begin
                check($sformatf("b2b_out%0d", no), out_if.state, bb_exp[no]);
                no++;
            end
            @(posedge clk); #1;
            if (acc) begin
                acc_t[ni] = t;
                ni++;
                if (ni < 3) in_if.state = bb_in[ni];
                else in_if.valid = 1'b0;
            end
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        check("b2b_count", 128'(no), 128'd3);
        check("b2b_interval1", 128'(acc_t[1] - acc_t[0]), 128'd6);
        check("b2b_interval2", 128'(acc_t[2] - acc_t[1]), 128'd6);

        // Random round trip through the inverse transform
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_state(rnd, res, lat);
            check($sformatf("roundtrip%0d", i), inv_mix(res), rnd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_enc.md
# mix_columns_enc

Sequential AES MixColumns unit for the encryption datapath: multiplies each 32-bit column of a 128-bit state by the fixed polynomial {03}x³+{01}x²+{01}x+{02} over GF(2⁸). It is the forward counterpart of the decryption-side inverse MixColumns multiplier ({0E,0B,0D,09}). It sits between ShiftRows and AddRoundKey in the cipher round and processes one column per clock behind valid/ready handshakes.

## Interface
- No parameters; AES state width is fixed at 128 bits.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream presents in_state.
- in_ready  output  1  block can accept a state.
- in_state  input  128  state to mix; byte k = bits [127-8k -: 8]; column c = bytes 4c..4c+3.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  mixed state, same byte ordering as in_state.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, register in_state into the working register, clear column counter col=0, go to CALC.
- CALC: each cycle replace column col with its mixed value; col increments 0→1→2→3. After col=3 is written, go to DONE. Column 0 is processed first.
- Per-column math, input bytes a0..a3, output b0..b3: b0=2a0^3a1^a2^a3; b1=a0^2a1^3a2^a3; b2=a0^a1^2a2^3a3; b3=3a0^a1^a2^2a3. Here 2x = xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0) and 3x = 2x^x. All arithmetic is 8-bit; there is no carry between bytes.
- DONE: out_valid=1 and out_state = working register. On out_ready, go to IDLE.
- While out_valid && !out_ready, out_state is held stable. There is no timeout.
- in_valid outside IDLE is ignored and nothing is captured. in_ready is combinational from state only, never from in_valid.
- Result handoff and the next acceptance never share a cycle; in_ready rises the cycle after the out handshake.
- Reset mid-operation: the FSM goes to IDLE, any partial result is discarded, and the working register is cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_state=128'h0, col=0, FSM=IDLE.
- Acceptance at edge T. Columns are written at edges T+1..T+4. out_valid is high from after edge T+4, giving a latency of 4 cycles from acceptance to valid.
- Minimum issue interval is 6 cycles: accept, 4×CALC, DONE with out_ready already high.
- Throughput is 1 state per 6 cycles with downstream always ready.
- The combinational path is one column mixer only: 4 xtime plus XOR trees, no more than 5 XOR levels.

## Structure
- Shared package/include holds:
  - AES reduction constant 8'h1B
  - state width 128 and column width 32
  - FSM state encodings IDLE/CALC/DONE
- Sub-module mix_coluna (combinational, 32-in/32-out) implements one column. It reuses the codebase's existing galois2 xtime block for 2x.
- The top level holds the FSM, the column counter, the working register and column select/replace muxing.

## Test plan
- Single column vectors (FIPS-197), each placed in column 0, rest zero:
  - db135345 → 8e4da1bc
  - f20a225c → 9fdc589d
  - d4d4d4d5 → d5d5d7d6
  - 2d26314c → 4d7ebdf8
  - 01010101 and c6c6c6c6 → unchanged
- Full state: in_state=d4bf5d30e0b452aeb84111f11e2798e5 → out_state=046681e5e0cb199a48f8d37a2806264c. out_valid rises exactly 4 cycles after acceptance.
- Backpressure:
  - out_ready=0 for 10 cycles after out_valid: out_state and out_valid are stable and in_ready stays 0.
  - in_valid pulsed with a different state during CALC/DONE: it is not captured.
- Reset mid-operation: assert rst_n=0 asynchronously during CALC at col=2. Immediately out_valid=0, out_state=0 and in_ready=1; the next accepted state produces a correct result.
- Back-to-back: 3 states streamed with out_ready tied high. Issue interval is 6 cycles and results come out in order.
- Round-trip: 1000 random states through mix_columns_enc and then the inverse MixColumns multiplier ({0E,0B,0D,09}) per column. Every state returns equal to the original input.
